// File: rtl/env_sweeper.sv
// Write-side walker over the environment cell memory: read-modify-write of every cell in
// scan order, subtracting a captured decay with saturation at zero (pheromone evaporation).
module env_sweeper #(
  parameter int X_bits    = 10,
  parameter int Y_bits    = 9,
  parameter int PIXELS_X  = 640,
  parameter int PIXELS_Y  = 480,
  parameter int CELL_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [CELL_BITS-1:0] decay_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_req_o,
  output logic [X_bits-1:0]    rd_x_o,
  output logic [Y_bits-1:0]    rd_y_o,
  input  logic                 rd_valid_i,
  input  logic [CELL_BITS-1:0] rd_data_i,
  output logic                 wr_en_o,
  output logic [X_bits-1:0]    wr_x_o,
  output logic [Y_bits-1:0]    wr_y_o,
  output logic [CELL_BITS-1:0] wr_data_o,
  input  logic                 wr_ready_i
);

  localparam logic [X_bits-1:0] LAST_X = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0] LAST_Y = Y_bits'(PIXELS_Y - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [X_bits-1:0]      cur_x_q;
  logic [Y_bits-1:0]      cur_y_q;
  logic [CELL_BITS-1:0]   decay_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_req_q;
  logic [X_bits-1:0]      rd_x_q;
  logic [Y_bits-1:0]      rd_y_q;
  logic                   wr_en_q;
  logic [X_bits-1:0]      wr_x_q;
  logic [Y_bits-1:0]      wr_y_q;
  logic [CELL_BITS-1:0]   wr_data_q;

  logic [X_bits-1:0]      nxt_x_d;
  logic [Y_bits-1:0]      nxt_y_d;
  logic                   last_cell_d;
  logic [CELL_BITS-1:0]   sat_d;

  // Scan-order successor; the last cell is caught separately so y never steps past LAST_Y.
  always_comb begin
    last_cell_d = (cur_x_q == LAST_X) && (cur_y_q == LAST_Y);
    if (cur_x_q == LAST_X) begin
      nxt_x_d = '0;
      nxt_y_d = cur_y_q + 1'b1;
    end else begin
      nxt_x_d = cur_x_q + 1'b1;
      nxt_y_d = cur_y_q;
    end
    sat_d = (rd_data_i < decay_q) ? '0 : (rd_data_i - decay_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      decay_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            decay_q  <= decay_i;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            rd_req_q <= 1'b1;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_valid_i) begin
            wr_data_q <= sat_d;
            wr_x_q    <= cur_x_q;
            wr_y_q    <= cur_y_q;
            wr_en_q   <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Outputs stay frozen until the write is accepted; the next read waits for it.
          if (wr_ready_i) begin
            wr_en_q <= 1'b0;
            if (last_cell_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_x_q  <= nxt_x_d;
              cur_y_q  <= nxt_y_d;
              rd_req_q <= 1'b1;
              rd_x_q   <= nxt_x_d;
              rd_y_q   <= nxt_y_d;
              state_q  <= S_READ;
            end
          end
        end
        S_DONE: begin
          cur_x_q <= '0;
          cur_y_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_req_o  = rd_req_q;
  assign rd_x_o    = rd_x_q;
  assign rd_y_o    = rd_y_q;
  assign wr_en_o   = wr_en_q;
  assign wr_x_o    = wr_x_q;
  assign wr_y_o    = wr_y_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_env_sweeper.sv
// Directed bench for env_sweeper on a 4x3 grid: a memory model answers reads one cycle late,
// expected writes are queued when read data is returned and checked when a write is accepted.
module tb_env_sweeper;

  localparam int PX = 4;
  localparam int PY = 3;
  localparam int NC = PX * PY;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [7:0] decay_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_req_o;
  logic [9:0] rd_x_o;
  logic [8:0] rd_y_o;
  logic       rd_valid_i;
  logic [7:0] rd_data_i;
  logic       wr_en_o;
  logic [9:0] wr_x_o;
  logic [8:0] wr_y_o;
  logic [7:0] wr_data_o;
  logic       wr_ready_i;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  env_sweeper #(
    .X_bits(10), .Y_bits(9), .PIXELS_X(PX), .PIXELS_Y(PY), .CELL_BITS(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .decay_i(decay_i),
    .busy_o(busy_o), .done_o(done_o),
    .rd_req_o(rd_req_o), .rd_x_o(rd_x_o), .rd_y_o(rd_y_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .wr_en_o(wr_en_o), .wr_x_o(wr_x_o), .wr_y_o(wr_y_o), .wr_data_o(wr_data_o),
    .wr_ready_i(wr_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic idle_cycles(input int n);
    rd_valid_i = 1'b1;
    rd_data_i  = 8'h33;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_rd_req", rd_req_o, 0);
      chk("idle_wr_en", wr_en_o, 0);
    end
    rd_valid_i = 1'b0;
    rd_data_i  = '0;
  endtask

  // dmode 0: memory returns dval everywhere; dmode 1: random contents.
  task automatic sweep(input logic [7:0] dec, input int dmode, input logic [7:0] dval,
                       input int stall_at, input int restart_at, input int reset_at);
    int         cyc, exp_idx, cur_idx, stall_left, writes, dones, exp_done;
    bit         pend, prev_wr, fin;
    logic [9:0] px;
    logic [8:0] py;
    logic [7:0] pd, rdv;
    exp_t       e;
    exp_t       got;
    exp_idx = 0; cur_idx = -1; writes = 0; dones = 0; cyc = 0;
    pend = 0; prev_wr = 0; fin = 0;
    px = '0; py = '0; pd = '0;
    stall_left = (stall_at >= 0) ? 4 : 0;
    exp_done = 3 * NC + 1 + stall_left;
    sb_q.delete();
    start_i = 1'b1;
    decay_i = dec;
    @(posedge clk); #1;
    decay_i = dec ^ 8'h5A;
    while (!fin && cyc < 200) begin
      cyc++;
      start_i = 1'b0;
      chk("busy", busy_o, (cyc < exp_done));
      chk("done", done_o, (cyc == exp_done));
      if (done_o) begin
        dones++;
        fin = 1;
        start_i = 1'b1;
      end
      rd_valid_i = pend;
      rd_data_i  = '0;
      if (pend) begin
        rdv = (dmode == 1) ? 8'($urandom_range(0, 255)) : dval;
        rd_data_i = rdv;
        e.x = 10'(cur_idx % PX);
        e.y = 9'(cur_idx / PX);
        e.d = (rdv < dec) ? 8'd0 : 8'(rdv - dec);
        sb_q.push_back(e);
      end
      pend = 0;
      if (rd_req_o) begin
        chk("rd_x", rd_x_o, exp_idx % PX);
        chk("rd_y", rd_y_o, exp_idx / PX);
        cur_idx = exp_idx;
        exp_idx++;
        pend = 1;
        if (cur_idx == restart_at) begin
          start_i = 1'b1;
          decay_i = 8'd9;
        end
      end
      wr_ready_i = 1'b0;
      if (wr_en_o) begin
        if (prev_wr) begin
          chk("wr_x_hold", wr_x_o, px);
          chk("wr_y_hold", wr_y_o, py);
          chk("wr_data_hold", wr_data_o, pd);
          chk("rd_req_in_write", rd_req_o, 0);
        end
        px = wr_x_o; py = wr_y_o; pd = wr_data_o;
        if (cur_idx == reset_at) begin
          reset_i = 1'b1;
          @(posedge clk); #1;
          reset_i = 1'b0;
          chk("rst_busy", busy_o, 0);
          chk("rst_wr_en", wr_en_o, 0);
          chk("rst_done", done_o, 0);
          chk("rst_rd_req", rd_req_o, 0);
          for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_done", done_o, 0);
            chk("rst_no_write", wr_en_o, 0);
          end
          sb_q.delete();
          return;
        end else if (cur_idx == stall_at && stall_left > 0) begin
          stall_left--;
          rd_valid_i = 1'b1;
          rd_data_i  = 8'hAA;
        end else begin
          wr_ready_i = 1'b1;
          chk("sb_level", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got.x = wr_x_o; got.y = wr_y_o; got.d = wr_data_o;
            chk("wr_x", got.x, e.x);
            chk("wr_y", got.y, e.y);
            chk("wr_data", got.d, e.d);
          end
          writes++;
        end
      end
      prev_wr = wr_en_o;
      @(posedge clk); #1;
    end
    start_i    = 1'b0;
    rd_valid_i = 1'b0;
    wr_ready_i = 1'b0;
    chk("sweep_finished", fin, 1);
    chk("write_count", writes, NC);
    chk("done_count", dones, 1);
    chk("sb_drained", sb_q.size(), 0);
    idle_cycles(3);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; decay_i = '0;
    rd_valid_i = 1'b0; rd_data_i = '0; wr_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_rd_req", rd_req_o, 0);
    chk("reset_rd_x", rd_x_o, 0);
    chk("reset_rd_y", rd_y_o, 0);
    chk("reset_wr_en", wr_en_o, 0);
    chk("reset_wr_x", wr_x_o, 0);
    chk("reset_wr_y", wr_y_o, 0);
    chk("reset_wr_data", wr_data_o, 0);
    reset_i = 1'b0;

    idle_cycles(3);
    sweep(8'd5,   0, 8'd20,  -1, -1, -1);
    sweep(8'd5,   0, 8'd3,   -1, -1, -1);
    sweep(8'd0,   0, 8'd255, -1, -1, -1);
    sweep(8'd5,   1, 8'd0,    3,  5, -1);
    sweep(8'd5,   0, 8'd20,  -1, -1,  6);
    sweep(8'd7,   1, 8'd0,   -1, -1, -1);
    sweep(8'd200, 1, 8'd0,    7, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
